// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package nibble_serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

  // Bits needed to index n nibbles; never narrower than one bit.
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle between a requesting datapath and the serial adder controller.
// Handshake: start is a one-cycle request accepted only while busy=0; the result is
// valid on the single cycle done=1 and stays on sum/cout/ovf until the next accepted start.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/nibble_serial_adder_ctrl_nibble_add_cin.sv
// 4-bit ripple carry-chain adder slice with carry-in; exposes the carry into bit 3 for overflow.
module nibble_add_cin (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       c3_o,
  output logic       c4_o
);

  logic cy;

  always_comb begin
    s_o  = '0;
    c3_o = 1'b0;
    cy   = ci_i;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) c3_o = cy;
      s_o[i] = x_i[i] ^ y_i[i] ^ cy;
      cy     = (x_i[i] & y_i[i]) | ((x_i[i] ^ y_i[i]) & cy);
    end
    c4_o = cy;
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequences one shared 4-bit adder slice over WIDTH/4 cycles, LS nibble first.
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  nibble_serial_adder_ctrl_if.slave    bus,
  output state_e                       state_o
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = idx_w(NIB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] x_nib, y_nib, s4;
  logic       c3, c4;

  assign x_nib = op_a_q[{idx_q, 2'b00} +: NIBBLE_W];
  assign y_nib = op_b_q[{idx_q, 2'b00} +: NIBBLE_W];

  nibble_add_cin u_slice (
    .x_i  (x_nib),
    .y_i  (y_nib),
    .ci_i (carry_q),
    .s_o  (s4),
    .c3_o (c3),
    .c4_o (c4)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        // Subtraction is A + ~B + 1, so the inverted operand and the +1 carry are latched here.
        if (bus.start) begin
          op_a_d  = bus.a;
          op_b_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[{idx_q, 2'b00} +: NIBBLE_W] = s4;
        carry_d = c4;
        if (idx_q == LAST_IDX) begin
          cout_d  = c4;
          ovf_d   = c3 ^ c4;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed table, random ops against an arithmetic model,
// and hand-written sequences for start-while-busy and reset mid-operation.
module tb_nibble_serial_adder_ctrl;
  import nibble_serial_adder_ctrl_pkg::*;

  localparam int W   = 16;
  localparam int NIB = W / 4;
  localparam int MAX_WAIT = 20;

  logic   clk;
  logic   rst;
  state_e state_o;
  int     n_checks;
  int     n_fail;
  int     done_cnt;

  nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vt[6];
  logic [W+1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, result packed as {cout, ovf, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         co, ov;
    if (sub) begin
      full = {1'b0, a} - {1'b0, b};
      s    = full[W-1:0];
      co   = (a >= b);
      ov   = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b};
      s    = full[W-1:0];
      co   = full[W];
      ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
    return {co, ov, s};
  endfunction

  // ---------------- driver ----------------
  // Pulses start, scrambles the live inputs while running, returns the number of rising
  // edges after the accepting edge until done was seen (MAX_WAIT means it never came).
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                        output int lat, output logic [W+1:0] res, output logic busy_at_done);
    @(negedge clk);
    bus.start = 1'b1; bus.a = ai; bus.b = bi; bus.sub = si;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < MAX_WAIT) begin
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    res          = {bus.cout, bus.ovf, bus.sum};
    busy_at_done = bus.busy;
  endtask

  // ---------------- test ----------------
  initial begin
    int           lat;
    logic [W+1:0] res;
    logic [W+1:0] exp;
    logic         bsy;
    int           c0;

    n_checks = 0; n_fail = 0; done_cnt = 0;
    rst = 1'b1; bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;

    vt[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[4] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[5] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_sum",  32'(bus.sum),  32'd0);
    check("reset_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
    check("reset_state", 32'(state_o), 32'(ST_IDLE));
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].sub, lat, res, bsy);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(NIB));
      check($sformatf("vec%0d_sum", i),  32'(res[W-1:0]), 32'(vt[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(res[W+1]),   32'(vt[i].cout));
      check($sformatf("vec%0d_ovf", i),  32'(res[W]),     32'(vt[i].ovf));
      check($sformatf("vec%0d_busy_at_done", i), 32'(bsy), 32'd1);
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", i), {30'd0, bus.busy, bus.done}, 32'd0);
      check($sformatf("vec%0d_sum_held", i), 32'(bus.sum), 32'(vt[i].sum));
    end

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = ra;
      rs = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_op(ra, rb, rs));
      run_op(ra, rb, rs, lat, res, bsy);
      exp = exp_q.pop_front();
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(NIB));
      check($sformatf("rnd%0d_result", i), 32'(res), 32'(exp));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Start while busy (RUN and DONE) must be ignored.
    @(negedge clk);
    c0 = done_cnt;
    bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    check("busy_ign_done_seen", 32'(bus.done), 32'd1);
    check("busy_ign_sum", 32'(bus.sum), 32'h3333);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_ign_idle_after_done", {30'd0, bus.busy, bus.done}, 32'd0);
    repeat (NIB + 4) @(negedge clk);
    #1;
    check("busy_ign_single_done", 32'(done_cnt - c0), 32'd1);
    check("busy_ign_sum_held", 32'(bus.sum), 32'h3333);
    check("busy_ign_no_rerun", 32'(bus.busy), 32'd0);

    // Reset two cycles into a run.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    c0 = done_cnt;
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    check("rst_mid_sum",  32'(bus.sum),  32'd0);
    check("rst_mid_state", 32'(state_o), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (NIB + 2) @(negedge clk);
    #1;
    check("rst_mid_no_done", 32'(done_cnt - c0), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, lat, res, bsy);
    check("post_rst_latency", 32'(lat), 32'(NIB));
    check("post_rst_result", 32'(res), 32'({1'b0, 1'b0, 16'h0002}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
